memref_mp: RTL and testbench

- Parametrised multi-port memory model for HIR-generated kernel testbenches.
- Holds an internal array of SIZE words of WIDTH bits.
- Provides NUM_WR write ports and NUM_RD read ports, with a configurable read latency and per-port read-valid.
- Detects write/write collisions and out-of-range accesses, so benches can flag scheduling bugs in generated hardware.

---
 rtl/memref_pkg.sv | 17 +
 rtl/memref_rd_pipe.sv | 40 ++++
 rtl/memref_mp.sv | 117 +++++++++++
 tb/tb_memref_mp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memref_pkg.sv
// memref_pkg: shared types, defaults and address-width helper for the
// multi-port memory model.
package memref_pkg;

  localparam int MEMREF_WIDTH_DEF = 32;
  localparam int MEMREF_SIZE_DEF  = 8;

  typedef struct packed {
    logic collision;
    logic range;
  } memref_err_t;

  function automatic int memref_addr_w(input int size);
    return (size <= 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/memref_rd_pipe.sv
// memref_rd_pipe: LAT-deep valid/data shift register for one read port.
// Output data holds its last value while valid is low.
module memref_rd_pipe
  import memref_pkg::*;
#(
  parameter int WIDTH = MEMREF_WIDTH_DEF,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [LAT-1:0]            vld_q;
  logic [LAT-1:0][WIDTH-1:0] dat_q;

  // shift valid every cycle; data only moves behind a valid token
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= en_i;
      if (en_i)
        dat_q[0] <= data_i;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1])
          dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign valid_o = vld_q[LAT-1];
  assign data_o  = dat_q[LAT-1];

endmodule

// File: rtl/memref_mp.sv
// memref_mp: multi-port memory model with read latency pipe and
// sticky collision/range flags. MEMREF_WR_FORWARD_EN selects write-first.
module memref_mp
  import memref_pkg::*;
#(
  parameter int WIDTH      = MEMREF_WIDTH_DEF,
  parameter int SIZE       = MEMREF_SIZE_DEF,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int RD_LATENCY = 1,
  localparam int AW        = memref_addr_w(SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*AW-1:0]    wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0]       rd_valid,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic                    err_collision,
  output logic                    err_range
);

  localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);

  logic [WIDTH-1:0] mem_q [SIZE];

  logic [NUM_WR-1:0]            wr_ok;
  logic [NUM_RD-1:0]            rd_ok;
  logic [NUM_RD-1:0][WIDTH-1:0] rd_word;
  logic                         coll;
  logic                         oor;
  memref_err_t                  err_q;
  memref_err_t                  err_d;

  // per-port enable qualified by the address being inside the array
  always_comb begin
    wr_ok = '0;
    rd_ok = '0;
    for (int i = 0; i < NUM_WR; i++)
      wr_ok[i] = wr_en[i] &&
        ({1'b0, wr_addr[i*AW +: AW]} < SIZE_W);
    for (int j = 0; j < NUM_RD; j++)
      rd_ok[j] = rd_en[j] &&
        ({1'b0, rd_addr[j*AW +: AW]} < SIZE_W);
  end

  // collision: any pair of in-range writes to one address
  always_comb begin
    coll = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int k = i + 1; k < NUM_WR; k++)
        if (wr_ok[i] && wr_ok[k] &&
            wr_addr[i*AW +: AW] == wr_addr[k*AW +: AW])
          coll = 1'b1;
    oor = |(wr_en & ~wr_ok) | |(rd_en & ~rd_ok);
  end

  // sticky error flags accumulate until reset
  always_comb begin
    err_d           = err_q;
    err_d.collision = err_q.collision | coll;
    err_d.range     = err_q.range | oor;
  end

  // error flag register
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= '0;
    else
      err_q <= err_d;
  end

  // array write; later ports override earlier ones on collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WR; i++)
        if (wr_ok[i])
          mem_q[wr_addr[i*AW +: AW]] <= wr_data[i*WIDTH +: WIDTH];
    end
  end

  // read word sampled into stage 1; out-of-range reads return zero
  always_comb begin
    rd_word = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      if (rd_ok[j])
        rd_word[j] = mem_q[rd_addr[j*AW +: AW]];
`ifdef MEMREF_WR_FORWARD_EN
      for (int i = 0; i < NUM_WR; i++)
        if (rd_ok[j] && wr_ok[i] &&
            wr_addr[i*AW +: AW] == rd_addr[j*AW +: AW])
          rd_word[j] = wr_data[i*WIDTH +: WIDTH];
`endif
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    memref_rd_pipe #(
      .WIDTH (WIDTH),
      .LAT   (RD_LATENCY)
    ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .en_i    (rd_en[j]),
      .data_i  (rd_word[j]),
      .valid_o (rd_valid[j]),
      .data_o  (rd_data[j*WIDTH +: WIDTH])
    );
  end

  assign err_collision = err_q.collision;
  assign err_range     = err_q.range;

endmodule

// File: tb/tb_memref_mp.sv
// tb_memref_mp: scoreboard bench for memref_mp, two configurations.
// Honours MEMREF_WR_FORWARD_EN for the read-during-write expectation.
module tb_memref_mp;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;

  // instance A: SIZE 8, 2 write ports, latency 1
  logic [1:0]  a_wr_en;
  logic [5:0]  a_wr_addr;
  logic [63:0] a_wr_data;
  logic [1:0]  a_rd_en;
  logic [5:0]  a_rd_addr;
  logic [1:0]  a_rd_valid;
  logic [63:0] a_rd_data;
  logic        a_ec;
  logic        a_er;

  // instance B: SIZE 6, 1 write port, latency 3
  logic [0:0]  b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [1:0]  b_rd_en;
  logic [5:0]  b_rd_addr;
  logic [1:0]  b_rd_valid;
  logic [63:0] b_rd_data;
  logic        b_ec;
  logic        b_er;

  int   cyc;
  int   nvec;
  int   nfail;
  exp_t sbq [4][$];

  memref_mp #(
    .WIDTH(32), .SIZE(8), .NUM_RD(2), .NUM_WR(2), .RD_LATENCY(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data),
    .err_collision(a_ec), .err_range(a_er)
  );

  memref_mp #(
    .WIDTH(32), .SIZE(6), .NUM_RD(2), .NUM_WR(1), .RD_LATENCY(3)
  ) u_b (
    .clk(clk), .rst(rst),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data),
    .err_collision(b_ec), .err_range(b_er)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pop and compare whenever a port presents rd_valid
  always @(negedge clk) begin
    logic [3:0]  vv;
    logic [31:0] dd [4];
    exp_t        e;
    vv    = {b_rd_valid, a_rd_valid};
    dd[0] = a_rd_data[31:0];
    dd[1] = a_rd_data[63:32];
    dd[2] = b_rd_data[31:0];
    dd[3] = b_rd_data[63:32];
    for (int p = 0; p < 4; p++) begin
      if (sbq[p].size() > 0 && sbq[p][0].due < cyc) begin
        e = sbq[p].pop_front();
        nvec++;
        nfail++;
        $display("FAIL missing_valid port%0d: no rd_valid, required data %h at cycle %0d",
                 p, e.data, e.due);
      end
      if (vv[p]) begin
        nvec++;
        if (sbq[p].size() == 0) begin
          nfail++;
          $display("FAIL unexpected_valid port%0d: rd_valid=1 data %h at cycle %0d, required none",
                   p, dd[p], cyc);
        end else begin
          e = sbq[p].pop_front();
          if (e.due != cyc || dd[p] !== e.data) begin
            nfail++;
            $display("FAIL read port%0d: got %h at cycle %0d, required %h at cycle %0d",
                     p, dd[p], cyc, e.data, e.due);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    a_wr_en = '0;
    a_rd_en = '0;
    b_wr_en = '0;
    b_rd_en = '0;
  endtask

  task automatic push(input int p, input int lat, input logic [31:0] d);
    exp_t e;
    e.due  = cyc + lat;
    e.data = d;
    sbq[p].push_back(e);
  endtask

  logic [31:0] rdw_exp;
  int          guard;

  initial begin
    cyc   = 0;
    nvec  = 0;
    nfail = 0;
    rst   = 1'b1;
    a_wr_addr = '0;
    a_wr_data = '0;
    a_rd_addr = '0;
    b_wr_addr = '0;
    b_wr_data = '0;
    b_rd_addr = '0;
    idle();
    tick();
    tick();
    chk("reset_a_valid", {62'd0, a_rd_valid}, 64'd0);
    chk("reset_a_data", a_rd_data, 64'd0);
    chk("reset_b_data", b_rd_data, 64'd0);
    chk("reset_flags", {60'd0, a_ec, a_er, b_ec, b_er}, 64'd0);
    rst = 1'b0;

    // preload A: mem[i] = i + 100
    for (int i = 0; i < 8; i++) begin
      a_wr_en   = 2'b01;
      a_wr_addr = {3'd0, 3'(i)};
      a_wr_data = {32'd0, 32'(i + 100)};
      tick();
    end
    idle();

    // B basic latency: write then read addr 5, valid 3 cycles later
    b_wr_en   = 1'b1;
    b_wr_addr = 3'd5;
    b_wr_data = 32'hDEADBEEF;
    tick();
    idle();
    b_rd_en   = 2'b01;
    b_rd_addr = {3'd0, 3'd5};
    push(2, 3, 32'hDEADBEEF);
    tick();
    idle();

    // A back-to-back dual read
    for (int i = 0; i < 3; i++) begin
      a_rd_en   = 2'b11;
      a_rd_addr = {3'(7 - i), 3'(i)};
      push(0, 1, 32'(100 + i));
      push(1, 1, 32'(107 - i));
      tick();
    end
    idle();
    tick();
    tick();

    // A write collision on addr 3
    chk("collision_before", {63'd0, a_ec}, 64'd0);
    a_wr_en   = 2'b11;
    a_wr_addr = {3'd3, 3'd3};
    a_wr_data = {32'h22, 32'h11};
    tick();
    idle();
    chk("collision_set", {63'd0, a_ec}, 64'd1);
    a_rd_en   = 2'b01;
    a_rd_addr = {3'd0, 3'd3};
    push(0, 1, 32'h22);
    tick();
    idle();

    // A read-during-write on addr 2
    a_wr_en   = 2'b01;
    a_wr_addr = {3'd0, 3'd2};
    a_wr_data = {32'd0, 32'hAA};
    tick();
`ifdef MEMREF_WR_FORWARD_EN
    rdw_exp = 32'hBB;
`else
    rdw_exp = 32'hAA;
`endif
    a_wr_en   = 2'b01;
    a_wr_data = {32'd0, 32'hBB};
    a_rd_en   = 2'b01;
    a_rd_addr = {3'd0, 3'd2};
    push(0, 1, rdw_exp);
    tick();
    idle();
    a_rd_en   = 2'b10;
    a_rd_addr = {3'd2, 3'd0};
    push(1, 1, 32'hBB);
    tick();
    idle();
    tick();
    chk("collision_sticky", {63'd0, a_ec}, 64'd1);
    chk("a_range_clear", {63'd0, a_er}, 64'd0);

    // B out-of-range write then read
    chk("range_before", {63'd0, b_er}, 64'd0);
    b_wr_en   = 1'b1;
    b_wr_addr = 3'd7;
    b_wr_data = 32'h55;
    tick();
    idle();
    chk("range_set", {63'd0, b_er}, 64'd1);
    b_rd_en   = 2'b10;
    b_rd_addr = {3'd7, 3'd0};
    push(3, 3, 32'd0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) tick();
    chk("range_sticky", {63'd0, b_er}, 64'd1);

    // reset while a B read is in flight: no valid may appear
    b_rd_en   = 2'b01;
    b_rd_addr = {3'd0, 3'd4};
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_b_out", {b_rd_valid, b_rd_data}, 66'd0);
    chk("post_rst_a_out", {a_rd_valid, a_rd_data}, 66'd0);
    chk("post_rst_flags", {60'd0, a_ec, a_er, b_ec, b_er}, 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_quiet", {62'd0, b_rd_valid}, 64'd0);

    // array contents survive reset
    b_rd_en   = 2'b01;
    b_rd_addr = {3'd0, 3'd5};
    push(2, 3, 32'hDEADBEEF);
    tick();
    idle();

    guard = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size() +
            sbq[3].size()) > 0 && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) begin
      nvec++;
      nfail++;
      $display("FAIL drain: expected reads still pending, required none");
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
